tmr_serial_tx: RTL

Transmit end of the triple-redundant serial link whose receive end majority-votes three lanes per bit. Accepts a parallel word over a valid/ready handshake and serializes it identically on three lanes, LSB first. Each frame is a start bit, the data bits, an even-parity bit, then a stop cycle. Sits between the word-producing logic and the pad drivers of the redundant link.

---
 rtl/tmr_serial_tx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tmr_serial_tx.sv
// tmr_serial_tx: transmit end of a triple-redundant serial link.
// Accepts a WIDTH-bit word over valid/ready and sends it on three identical lanes as
// start bit, data bits LSB first, even-parity bit, then one stop cycle.
// Optional feature macro: TMR_TX_FAULT_INJECT_EN adds fi_en/fi_lane to invert one lane
// during data and parity bits.
module tmr_serial_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [2:0]       tx_lane,
  output logic             tx_frame,
`ifdef TMR_TX_FAULT_INJECT_EN
  output logic             busy,
  input  logic             fi_en,
  input  logic [1:0]       fi_lane
`else
  output logic             busy
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e           state_q;
  logic [2:0]       lane_q;
  logic [WIDTH-1:0] shift_q;
  logic [CntW-1:0]  cnt_q;
  logic             parity_q;
  logic             accept;

  // A new word may be taken while idle or during the stop cycle (back-to-back frames).
  always_comb begin
    in_ready = (state_q == StIdle) || (state_q == StStop);
    accept   = in_valid && in_ready;
  end

  // Frame sequencer; lane, tx_frame and busy are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lane_q   <= 3'b000;
      tx_frame <= 1'b0;
      busy     <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StStop: begin
          if (accept) begin
            state_q  <= StStart;
            lane_q   <= 3'b111;
            tx_frame <= 1'b1;
            busy     <= 1'b1;
            shift_q  <= in_data;
            parity_q <= ^in_data;
          end else begin
            state_q  <= StIdle;
            lane_q   <= 3'b000;
            tx_frame <= 1'b0;
            busy     <= 1'b0;
          end
        end
        StStart: begin
          state_q <= StData;
          lane_q  <= {3{shift_q[0]}};
          shift_q <= shift_q >> 1;
          cnt_q   <= '0;
        end
        StData: begin
          if (cnt_q == CntLast) begin
            state_q <= StParity;
            lane_q  <= {3{parity_q}};
          end else begin
            lane_q  <= {3{shift_q[0]}};
            shift_q <= shift_q >> 1;
            cnt_q   <= cnt_q + CntW'(1);
          end
        end
        StParity: begin
          state_q  <= StStop;
          lane_q   <= 3'b000;
          tx_frame <= 1'b0;
          busy     <= 1'b1;
        end
        default: begin
          state_q  <= StIdle;
          lane_q   <= 3'b000;
          tx_frame <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef TMR_TX_FAULT_INJECT_EN
  logic [2:0] fi_mask;

  // Inversion mask applied on the output; fi inputs act in the cycle of the bit they hit.
  always_comb begin
    fi_mask = 3'b000;
    if (fi_en && (state_q == StData || state_q == StParity)) begin
      case (fi_lane)
        2'd0:    fi_mask = 3'b001;
        2'd1:    fi_mask = 3'b010;
        2'd2:    fi_mask = 3'b100;
        default: fi_mask = 3'b000;
      endcase
    end
  end

  assign tx_lane = lane_q ^ fi_mask;
`else
  assign tx_lane = lane_q;
`endif

endmodule
